// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the data memory load/store unit.
package data_mem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } size_e;

    localparam int unsigned DATA_W_32 = 32;
    localparam int unsigned DATA_W_64 = 64;

    function automatic int unsigned size_bytes(size_e s);
        return 32'd1 << s;
    endfunction

endpackage

// File: rtl/data_mem_lsu_load_extend.sv
// Combinational load formatter: keeps the low size bytes and sign- or zero-extends to DATA_W.
module load_extend
    import data_mem_pkg::*;
#(
    parameter int unsigned DATA_W = 64
) (
    input  logic [DATA_W-1:0] raw_i,
    input  size_e             size_i,
    input  logic              unsigned_i,
    output logic [DATA_W-1:0] ext_o
);

    int unsigned       nbits;
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] top_bit;
    logic              neg;

    // A full-width access yields an all-ones mask, so the unsigned flag has no effect.
    always_comb begin
        nbits = 8 * size_bytes(size_i);
        if (nbits >= DATA_W) begin
            mask = '1;
        end else begin
            mask = (DATA_W'(1) << nbits) - DATA_W'(1);
        end
        top_bit = mask & ~(mask >> 1);
        neg     = !unsigned_i && (|(raw_i & top_bit));
        ext_o   = (raw_i & mask) | (neg ? ~mask : '0);
    end

endmodule

// File: rtl/data_mem_lsu.sv
// Byte-addressed little-endian data memory with sized loads/stores, error checking
// and a one-entry registered response behind a valid/ready handshake.
module data_mem_lsu
    import data_mem_pkg::*;
#(
    parameter int unsigned ADDR_W    = 64,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned DEPTH     = 256,
    parameter logic [7:0]  INIT_BYTE = 8'hFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned NB_MAX = DATA_W / 8;

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    // Contents survive reset; only the power-up value is defined.
    logic [7:0] mem_q [DEPTH] = '{default: INIT_BYTE};

    logic [0:0]        state_q, state_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    size_e             size;
    int unsigned       nbytes;
    logic [ADDR_W:0]   nbytes_w;
    logic [ADDR_W:0]   addr_end;
    logic              misaligned;
    logic              out_of_range;
    logic              bad_size;
    logic              req_err;
    logic              accept;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] raw;
    logic [DATA_W-1:0] ext;

    assign size         = size_e'(req_size);
    assign nbytes       = size_bytes(size);
    assign nbytes_w     = (ADDR_W+1)'(nbytes);
    assign addr_end     = {1'b0, req_addr} + nbytes_w;
    assign misaligned   = |(req_addr & (nbytes_w[ADDR_W-1:0] - ADDR_W'(1)));
    assign out_of_range = addr_end > (ADDR_W+1)'(DEPTH);
    assign bad_size     = (size == SZ_D) && (DATA_W == DATA_W_32);
    assign req_err      = misaligned || out_of_range || bad_size;

    assign req_ready = (state_q == ST_EMPTY) || rsp_ready;
    assign accept    = req_valid && req_ready && rst_n;
    assign idx       = req_addr[IDX_W-1:0];

    always_comb begin
        raw = '0;
        for (int unsigned k = 0; k < NB_MAX; k++) begin
            raw[8*k +: 8] = mem_q[idx + IDX_W'(k)];
        end
    end

    load_extend #(
        .DATA_W (DATA_W)
    ) u_load_extend (
        .raw_i      (raw),
        .size_i     (size),
        .unsigned_i (req_unsigned),
        .ext_o      (ext)
    );

    always_ff @(posedge clk) begin
        if (accept && req_write && !req_err) begin
            for (int unsigned k = 0; k < NB_MAX; k++) begin
                if (k < nbytes) begin
                    mem_q[idx + IDX_W'(k)] <= req_wdata[8*k +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        if (accept) begin
            state_d = ST_FULL;
            err_d   = req_err;
            rdata_d = (req_err || req_write) ? '0 : ext;
        end else if (rsp_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign rsp_valid = (state_q == ST_FULL);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Self-checking bench for data_mem_lsu: directed scenarios plus randomized traffic against a byte-array model.
module tb_data_mem_lsu;

    localparam int unsigned AW    = 64;
    localparam int unsigned DW    = 64;
    localparam int unsigned DEPTH = 256;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [1:0]    req_size = 2'b00;
    logic          req_unsigned = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;

    always #5 clk = ~clk;

    data_mem_lsu #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .DEPTH     (DEPTH),
        .INIT_BYTE (8'hFF)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    logic [7:0]  ref_mem [DEPTH];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Reference behaviour: applies a request to ref_mem and returns the expected response.
    function automatic void model(input logic wr, input logic [1:0] sz, input logic uns,
                                  input logic [63:0] addr, input logic [63:0] wd,
                                  output logic [63:0] rd, output logic err);
        int unsigned nb;
        logic [64:0] end_a;
        nb    = 1 << sz;
        end_a = {1'b0, addr} + 65'(nb);
        err   = ((addr & (64'(nb) - 64'd1)) != 64'd0) || (end_a > 65'(DEPTH));
        rd    = '0;
        if (err) return;
        if (wr) begin
            for (int unsigned i = 0; i < nb; i++) ref_mem[int'(addr) + int'(i)] = wd[8*i +: 8];
            return;
        end
        for (int unsigned i = 0; i < nb; i++) rd[8*i +: 8] = ref_mem[int'(addr) + int'(i)];
        if (!uns && nb < 8 && rd[8*nb-1]) rd = rd | ~((64'd1 << (8*nb)) - 64'd1);
    endfunction

    // Issue one request with rsp_ready high; called at posedge+1, returns at posedge+1.
    task automatic xfer(input string tag, input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [63:0] addr, input logic [63:0] wd);
        logic [63:0] erd;
        logic        eerr;
        req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd; rsp_ready = 1'b1;
        #1;
        check({tag, ".ready"}, 64'(req_ready), 64'd1);
        model(wr, sz, uns, addr, wd, erd, eerr);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check({tag, ".valid"}, 64'(rsp_valid), 64'd1);
        check({tag, ".rdata"}, rsp_rdata, erd);
        check({tag, ".err"}, 64'(rsp_err), 64'(eerr));
    endtask

    task automatic idle(input logic rdy);
        req_valid = 1'b0; rsp_ready = rdy;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [63:0] erd, hold_rd;
        logic        eerr;
        logic [63:0] a;
        foreach (ref_mem[i]) ref_mem[i] = 8'hFF;

        #1;
        check("reset.valid", 64'(rsp_valid), 64'd0);
        check("reset.rdata", rsp_rdata, 64'd0);
        check("reset.err", 64'(rsp_err), 64'd0);
        check("reset.ready", 64'(req_ready), 64'd1);
        #11 rst_n = 1'b1;
        @(posedge clk); #1;

        xfer("ld_d_0", 1'b0, 2'b11, 1'b0, 64'd0, '0);
        xfer("st_w_8", 1'b1, 2'b10, 1'b0, 64'd8, 64'h1234_5678_8000_00AA);
        xfer("ld_w_s", 1'b0, 2'b10, 1'b0, 64'd8, '0);
        xfer("ld_w_u", 1'b0, 2'b10, 1'b1, 64'd8, '0);
        xfer("ld_b_s", 1'b0, 2'b00, 1'b0, 64'd8, '0);
        xfer("ld_h_mis", 1'b0, 2'b01, 1'b0, 64'd3, '0);
        xfer("st_d_252", 1'b1, 2'b11, 1'b0, 64'd252, 64'h0123_4567_89AB_CDEF);
        xfer("ld_w_252", 1'b0, 2'b10, 1'b1, 64'd252, '0);
        xfer("ld_d_248", 1'b0, 2'b11, 1'b0, 64'd248, '0);
        xfer("ld_w_253", 1'b0, 2'b10, 1'b0, 64'd253, '0);
        xfer("ld_b_256", 1'b0, 2'b00, 1'b0, 64'd256, '0);
        xfer("ld_d_wrap", 1'b0, 2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, '0);
        xfer("st_b_40", 1'b1, 2'b00, 1'b0, 64'd40, 64'hFFFF_FFFF_FFFF_FF5A);
        xfer("ld_b_40", 1'b0, 2'b00, 1'b1, 64'd40, '0);
        idle(1'b1);
        check("drain.valid", 64'(rsp_valid), 64'd0);

        // Backpressure: response held while a store waits at the input.
        model(1'b0, 2'b10, 1'b0, 64'd8, '0, hold_rd, eerr);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 64'd8; rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_write = 1'b1; req_size = 2'b00; req_wdata = 64'h11;
        for (int i = 0; i < 3; i++) begin
            check("bp.ready", 64'(req_ready), 64'd0);
            check("bp.valid", 64'(rsp_valid), 64'd1);
            check("bp.rdata", rsp_rdata, hold_rd);
            check("bp.err", 64'(rsp_err), 64'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        #1;
        check("bp.release_ready", 64'(req_ready), 64'd1);
        model(1'b1, 2'b00, 1'b0, 64'd8, 64'h11, erd, eerr);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("bp.st_valid", 64'(rsp_valid), 64'd1);
        check("bp.st_rdata", rsp_rdata, 64'd0);
        xfer("bp.ld_w", 1'b0, 2'b10, 1'b1, 64'd8, '0);

        // Reset while a response is pending; a store held at the input must not commit.
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_addr = 64'd40; req_wdata = 64'h77;
        #2 rst_n = 1'b0;
        #1;
        check("rst.valid", 64'(rsp_valid), 64'd0);
        check("rst.rdata", rsp_rdata, 64'd0);
        check("rst.ready", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        check("rst.no_accept", 64'(rsp_valid), 64'd0);
        req_valid = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        xfer("rst.ld_b_40", 1'b0, 2'b00, 1'b1, 64'd40, '0);
        xfer("rst.ld_w_8", 1'b0, 2'b10, 1'b0, 64'd8, '0);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) == 0) a = {$urandom, $urandom};
            else a = 64'($urandom_range(0, 263));
            xfer($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), a, {$urandom, $urandom});
            if ($urandom_range(0, 4) == 0) begin
                idle(1'b1);
                check($sformatf("rnd%0d.idle", n), 64'(rsp_valid), 64'd0);
            end
        end

        for (int unsigned b = 0; b < DEPTH; b += 8) begin
            xfer($sformatf("sweep%0d", b), 1'b0, 2'b11, 1'b0, 64'(b), '0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/data_mem_lsu.md
# data_mem_lsu

Parametrised, byte-addressed little-endian data memory with sized loads/stores (byte/half/word/double), sign or zero extension on loads, alignment and range checking, and a registered response behind a valid/ready handshake. It is the next-generation data memory for the core's MEM stage and replaces the combinational, byte-wide-only memory. Stores commit on the accepting clock edge. Every accepted request returns exactly one response one cycle later, or later if the response is held by backpressure.

## Interface
- ADDR_W, 64, request address width
- DATA_W, 64, data width; legal values 32 or 64
- DEPTH, 256, memory size in bytes; power of two
- INIT_BYTE, 8'hFF, value of every memory byte at time zero
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 double
- req_unsigned  in  1  load only: 1 = zero-extend, 0 = sign-extend
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data; low (1<<req_size) bytes used
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  DATA_W  extended load data; 0 for stores and errors
- rsp_err  out  1  request was misaligned, out of range, or an illegal size

## Operation
- Acceptance: request accepted when req_valid && req_ready. req_ready = !rsp_valid || rsp_ready, which gives a one-entry response register with full throughput.
- nbytes = 1 << req_size.
- Error if any of the following holds:
  - req_addr % nbytes != 0
  - req_addr + nbytes > DEPTH, evaluated at full ADDR_W+1 width with no wrap-around
  - req_size == 11 with DATA_W == 32
- On an error, memory is untouched, rsp_err = 1 and rsp_rdata = 0.
- Store, no error: bytes req_wdata[8k+7:8k] are written to mem[req_addr+k] for k = 0..nbytes-1 at the accepting edge. The response has rsp_err = 0 and rsp_rdata = 0.
- Load, no error: assemble {mem[addr+nbytes-1] … mem[addr]}. The value is sign-extended from its MSB when req_unsigned = 0, otherwise zero-extended, to DATA_W. req_unsigned is ignored for a double, and for a word when DATA_W = 32.
- Load data is sampled at the accepting edge. A load accepted the cycle after a store sees the stored bytes.
- Response state: two states, EMPTY (rsp_valid = 0) and FULL (rsp_valid = 1).
  - EMPTY → FULL on accept.
  - FULL → FULL on accept && rsp_ready; the register is overwritten with the new response.
  - FULL → EMPTY on rsp_ready && !accept.
  - While FULL and !rsp_ready, rsp_* are held stable.
- Memory contents are not affected by rst_n. They are initialised to INIT_BYTE only at time zero.

## Timing
- Latency: accept at edge N → rsp_valid = 1 after edge N, visible in cycle N+1.
- Reset: rsp_valid = 0, rsp_rdata = 0, rsp_err = 0 immediately on rst_n low. req_ready = 1 while in reset.
- Reset mid-operation: a pending response is discarded. A store committed at an earlier edge stays committed. No request is accepted while rst_n = 0.
- Backpressure: rsp_valid && !rsp_ready → req_ready = 0 in the same cycle (combinational), and no request is accepted.
- Simultaneous response drain and new accept: the response is replaced back-to-back with no bubble.
- Address 0 and address DEPTH-nbytes are legal. DEPTH-nbytes+1 is out of range if aligned; a misaligned address reports an error either way.

## Structure
- Package data_mem_pkg holds:
  - enum size_e {SZ_B, SZ_H, SZ_W, SZ_D}
  - function size_bytes(size_e)
  - localparams for the legal DATA_W values
- Sub-module load_extend: combinational; inputs are the raw bytes, size and unsigned flag; output is the DATA_W extended value.
- The top level holds the byte array, the error check, the store loop and the response register/FSM.

## Test plan
- Reset, then load double from address 0 → rsp_rdata = 64'hFFFF_FFFF_FFFF_FFFF, rsp_err = 0, one cycle after accept.
- Store word 32'h8000_00AA at addr 8, then load word signed → 64'hFFFF_FFFF_8000_00AA. Load word unsigned → 64'h0000_0000_8000_00AA. Load byte at addr 8 signed → 64'hFFFF_FFFF_FFFF_FFAA.
- Load half from addr 3 → rsp_err = 1, rdata = 0. Store double at addr DEPTH-4 → rsp_err = 1, and a subsequent load of those bytes returns the bytes unchanged.
- Hold rsp_ready = 0 for 3 cycles with req_valid = 1 → req_ready = 0 throughout, rsp_* stable, no memory change. Release → the next request is accepted the same cycle.
- Back-to-back store byte 8'h5A at addr 40 then load byte unsigned at addr 40 → load returns 64'h5A.
- Assert rst_n low while rsp_valid = 1 → rsp_valid = 0 immediately. Memory contents are retained after reset.
